// File: rtl/tlc_multiway_if.sv
// Signal bundle between the intersection sequencer and its sensor/lamp side.
// master: sensor front-end (drives mode/flash/req, observes lamps).
// slave : tlc_multiway controller.
interface tlc_multiway_if #(
  parameter int NUM_DIR = 4
);
  logic                   mode;
  logic                   flash;
  logic [NUM_DIR-1:0]     req;
  logic [3*NUM_DIR-1:0]   lightout;
  logic [2:0]             active_dir;
  logic [1:0]             phase;

  modport master (output mode, flash, req, input lightout, active_dir, phase);
  modport slave  (input mode, flash, req, output lightout, active_dir, phase);
endinterface

// File: rtl/tlc_multiway.sv
// N-way traffic light sequencer with cycle-count phase timers.
// Fixed-time or vehicle-actuated rotation, plus night flashing mode.
// Optional feature macro: TLC_ALL_RED_EN inserts an all-red clearance phase
// after every yellow and after flash exit.

// Per-direction lamp decode: {green,yellow,red}.
module tlc_lamp (
  input  logic [1:0] phase,
  input  logic       is_act,
  input  logic       blink,
  output logic [2:0] lamp
);
  // decode one approach's lamps from the (next) controller state
  always_comb begin
    lamp = 3'b001;
    if (phase == 2'b11)     lamp = {2'b00, blink};
    else if (is_act) begin
      case (phase)
        2'b00:   lamp = 3'b100;
        2'b01:   lamp = 3'b010;
        default: lamp = 3'b001;
      endcase
    end
  end
endmodule

module tlc_multiway #(
  parameter int NUM_DIR        = 4,
  parameter int GREEN_CYCLES   = 50,
  parameter int YELLOW_CYCLES  = 10,
  parameter int ALL_RED_CYCLES = 2,
  parameter int FLASH_HALF     = 5
) (
  input logic         clk,
  input logic         rst,
  tlc_multiway_if.slave bus
);
  localparam int M0   = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int M1   = (ALL_RED_CYCLES > FLASH_HALF) ? ALL_RED_CYCLES : FLASH_HALF;
  localparam int MAXD = (M0 > M1) ? M0 : M1;
  localparam int TW   = $clog2(MAXD) + 1;

  localparam logic [TW-1:0] G_LD  = TW'(GREEN_CYCLES - 1);
  localparam logic [TW-1:0] Y_LD  = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] F_LD  = TW'(FLASH_HALF - 1);
`ifdef TLC_ALL_RED_EN
  localparam logic [TW-1:0] AR_LD = TW'(ALL_RED_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_FLASH  = 2'b11
  } phase_e;

  phase_e               phase_q, phase_d;
  logic [2:0]           dir_q, dir_d;     // direction holding right-of-way
  logic [2:0]           tgt_q, tgt_d;     // next green, chosen at green expiry
  logic [TW-1:0]        tmr_q, tmr_d;     // shared phase / flash half-period timer
  logic                 blink_q, blink_d;
  logic [NUM_DIR-1:0]   pend_q, pend_d, pend_set, clr;
  logic [3*NUM_DIR-1:0] light_d, light_q, light_rst;

  logic [NUM_DIR-1:0]   others;
  logic                 act_hit;
  logic [2:0]           act_nxt, fix_nxt;

  // actuated search: first pending approach after the active one, with wrap
  always_comb begin
    int idx;
    logic found;
    pend_set = pend_q | bus.req;
    for (int d = 0; d < NUM_DIR; d++)
      others[d] = pend_set[d] && (d != int'(dir_q));
    act_hit = |others;
    act_nxt = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k < NUM_DIR; k++) begin
      idx = (int'(dir_q) + k) % NUM_DIR;
      if (!found && others[idx]) begin
        act_nxt = 3'(idx);
        found   = 1'b1;
      end
    end
    fix_nxt = 3'((int'(dir_q) + 1) % NUM_DIR);
  end

  // phase sequencing; flash has priority over normal timer expiry
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    tmr_d   = tmr_q - 1'b1;
    blink_d = blink_q;
    clr     = '0;
    if (bus.flash) begin
      if (phase_q != PH_FLASH) begin
        phase_d = PH_FLASH;
        tmr_d   = F_LD;
        blink_d = 1'b1;
      end else if (tmr_q == '0) begin
        tmr_d   = F_LD;
        blink_d = ~blink_q;
      end
    end else if (phase_q == PH_FLASH) begin
`ifdef TLC_ALL_RED_EN
      // clearance parked on the last approach so fixed rotation resumes at 0
      phase_d = PH_ALLRED;
      dir_d   = 3'(NUM_DIR - 1);
      tgt_d   = '0;
      tmr_d   = AR_LD;
`else
      phase_d = PH_GREEN;
      dir_d   = '0;
      tmr_d   = G_LD;
      clr     = NUM_DIR'(1);
`endif
    end else if (tmr_q == '0) begin
      case (phase_q)
        PH_GREEN: begin
          if (bus.mode && !act_hit) begin
            tmr_d = G_LD;                 // nobody else waiting: hold green
          end else begin
            phase_d = PH_YELLOW;
            tmr_d   = Y_LD;
            tgt_d   = bus.mode ? act_nxt : fix_nxt;
          end
        end
        PH_YELLOW: begin
`ifdef TLC_ALL_RED_EN
          phase_d = PH_ALLRED;
          tmr_d   = AR_LD;
`else
          phase_d = PH_GREEN;
          dir_d   = tgt_q;
          tmr_d   = G_LD;
          clr     = NUM_DIR'(1) << tgt_q;
`endif
        end
        PH_ALLRED: begin
          phase_d = PH_GREEN;
          dir_d   = tgt_q;
          tmr_d   = G_LD;
          clr     = NUM_DIR'(1) << tgt_q;
        end
        default: ;
      endcase
    end
    // clear on green entry beats a same-cycle request
    pend_d = pend_set & ~clr;
  end

  // lamp decode per approach, fed from next state so lamps are registered
  for (genvar d = 0; d < NUM_DIR; d++) begin : g_lamp
    tlc_lamp u_lamp (
      .phase  (phase_d),
      .is_act (dir_d == 3'(d)),
      .blink  (blink_d),
      .lamp   (light_d[3*NUM_DIR-1-3*d -: 3])
    );
    assign light_rst[3*NUM_DIR-1-3*d -: 3] = (d == 0) ? 3'b100 : 3'b001;
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      dir_q   <= '0;
      tgt_q   <= '0;
      tmr_q   <= G_LD;
      blink_q <= 1'b1;
      pend_q  <= '0;
      light_q <= light_rst;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      tmr_q   <= tmr_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      light_q <= light_d;
    end
  end

  assign bus.lightout   = light_q;
  assign bus.active_dir = dir_q;
  assign bus.phase      = phase_q;
endmodule

// File: doc/tlc_multiway.md
# tlc_multiway

Parametrised multi-direction traffic light controller driving an N-way intersection from a single clock. It rotates right-of-way through NUM_DIR approaches using cycle-count phase timers. It supports fixed-time and vehicle-actuated sequencing plus a night flashing mode. It replaces the fixed four-way, $time-based controller as the intersection sequencer fed by sensor front-ends.

## Interface
- NUM_DIR, 4: number of approaches, 2..8; direction 0 has highest output bits.
- GREEN_CYCLES, 50: green duration in clocks, >=1.
- YELLOW_CYCLES, 10: yellow duration in clocks, >=1.
- ALL_RED_CYCLES, 2: all-red clearance in clocks, >=1; used only with TLC_ALL_RED_EN.
- FLASH_HALF, 5: half-period of flashing red in clocks, >=1.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed-time rotation, 1 = actuated (serve only requested approaches).
- flash  input  1  1 = night flashing mode.
- req  input  NUM_DIR  per-direction vehicle request pulses/levels.
- lightout  output  3*NUM_DIR  per-direction {green,yellow,red}; direction d at bits [3*NUM_DIR-1-3d -: 3].
- active_dir  output  3  direction currently holding right-of-way.
- phase  output  2  00 GREEN, 01 YELLOW, 10 ALLRED, 11 FLASH.

## Operation
- Exactly one direction is non-red outside FLASH; all others show red (001).
- GREEN: active_dir shows 100. On expiry, go to YELLOW on the same direction, unless actuated hold applies.
- YELLOW: active_dir shows 010. On expiry, go to ALLRED if enabled; otherwise go to GREEN of the next direction.
- ALLRED: all directions show 001. On expiry, go to GREEN of the next direction.
- Next direction, fixed mode (mode=0): (active_dir+1) mod NUM_DIR.
- Next direction, actuated mode (mode=1): first direction with pending bit set, searching active_dir+1 upward with wrap, excluding active_dir.
- Actuated hold: if no other direction is pending at green expiry, remain in GREEN on the same direction and reload the timer.
- mode is sampled only at green expiry.
- Pending register: pending[d] is set whenever req[d]=1. It is cleared on the edge entering GREEN for d; clear wins over a same-cycle set. Requests are latched in every phase, including FLASH.
- FLASH: when flash=1 is sampled, enter FLASH on that edge from any phase.
  - Green/yellow bits are 0 in FLASH.
  - All red bits are 1 for FLASH_HALF cycles, then 0 for FLASH_HALF cycles, repeating; the first FLASH cycle is lit.
  - When flash=0 is sampled, go to ALLRED with active_dir=NUM_DIR-1 if enabled, else go directly to GREEN of direction 0. After ALLRED, the next direction resolves to 0 in fixed mode.
- Reset: phase=GREEN, active_dir=0, lightout = direction 0 green and others red (12'o4111 for NUM_DIR=4), pending=0, timer loaded, blink=lit. rst overrides flash and all other inputs.

## Timing
- Single down-counter, width $clog2(max duration)+1.
- The counter is loaded with duration-1 on phase entry. The phase exits on the edge where counter==0; otherwise the counter decrements.
- Each phase is therefore visible for exactly its configured cycle count. An actuated-hold green repeats in GREEN_CYCLES blocks.
- Outputs are registered and change only on the transition edge, with zero extra latency.
- req affects direction selection when it was sampled on or before the green-expiry edge.
- FLASH entry and exit take effect on the edge where flash is sampled.
- Fixed-mode full rotation period: NUM_DIR*(GREEN_CYCLES+YELLOW_CYCLES+ALL_RED_CYCLES) with TLC_ALL_RED_EN; ALL_RED_CYCLES term omitted without it.

## Configuration
- TLC_ALL_RED_EN defined: the ALLRED clearance phase is inserted after every yellow and after flash exit.
- Undefined: yellow goes directly to the next green, phase code 10 never appears, and ALL_RED_CYCLES is ignored.

## Test plan
All scenarios use NUM_DIR=4, G=4, Y=2, AR=1, FLASH_HALF=2, TLC_ALL_RED_EN, unless noted.
- Reset then mode=0, 28 cycles: 12'o4111 for 4 cycles, 2111 for 2, 1111 for 1, then 1411 (dir1 green). Back to 4111 at cycle 28.
- mode=1, req=0: dir0 stays 4111 indefinitely.
- mode=1, pulse req[2] for one cycle during dir0 green: after Y+AR, dir2 green 1141; dir1 skipped; pending[2] cleared.
- flash=1 mid-yellow: the next edge gives phase=11 and lightout 1111,1111,0000,0000 repeating. flash=0 gives ALLRED 1 cycle, then 4111.
- rst asserted mid-ALLRED for 1 cycle: next edge gives 4111, active_dir=0, pending=0, and a full 4-cycle green.
- TLC_ALL_RED_EN undefined, mode=0: 4111 for 4 cycles, 2111 for 2, then 1411 immediately; phase never reads 10.
